// File: rtl/seven_hex_reader_pkg.sv
// rtl/seven_hex_reader_pkg.sv - shared glyph constants and FSM state type for the segment reader
// Glyph set matches the seven_hex driver so encoder and reader cannot diverge; bit 6 = segment A.
package seven_hex_reader_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
  localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

endpackage

// File: rtl/seven_hex_reader_if.sv
// rtl/seven_hex_reader_if.sv - byte delivery handshake between segment reader and its consumer
interface seven_hex_reader_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic [1:0] err;

  modport master (output valid, output data, output err, input ready);
  modport slave  (input valid, input data, input err, output ready);
endinterface

// File: rtl/seven_hex_reader_seg7.sv
// rtl/seven_hex_reader_seg7.sv - combinational 7-segment glyph to hex nibble decoder
// Unrecognised patterns (blank included) decode to 0 with err raised.
module seg7_to_nibble
  import seven_hex_reader_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       nibble,
  output logic             err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_hex_reader.sv
// rtl/seven_hex_reader.sv - reads two 7-segment digits, debounces, decodes and offers the byte
// Synchronizer -> stability counter -> SETTLE/HOLD FSM with sticky overrun flag.
module seven_hex_reader
  import seven_hex_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SEG_W-1:0]      seg_a,
  input  logic [SEG_W-1:0]      seg_b,
  input  logic                  clr_ovr,
  output logic                  ovr,
  seven_hex_reader_if.master    bus
);

  localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [2*SEG_W-1:0] sync1, sync2, sample, last_rep;
  logic [CW-1:0]      cnt;
  logic               first, stable, is_new, capture, set_ovr;
  logic [3:0]         nib_a, nib_b;
  logic               err_a, err_b;
  logic [7:0]         data_q;
  logic [1:0]         err_q;
  state_t             state, state_n;

  assign sample = sync2 ^ {(2*SEG_W){ACTIVE_LOW}};
  assign stable = (cnt == CNT_MAX);
  assign is_new = stable & ((sample != last_rep) | first);

  // Comparing the flop about to load (sync1) with the current sample zeroes the
  // counter on the same edge the changed sample lands, keeping latency at 2+N+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= {seg_a, seg_b};
      sync2 <= sync1;
      if (sync1 != sync2)
        cnt <= '0;
      else if (!stable)
        cnt <= cnt + 1'b1;
    end
  end

  seg7_to_nibble u_dec_a (.seg(sample[2*SEG_W-1:SEG_W]), .nibble(nib_a), .err(err_a));
  seg7_to_nibble u_dec_b (.seg(sample[SEG_W-1:0]),       .nibble(nib_b), .err(err_b));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SETTLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      SETTLE: if (is_new)    state_n = HOLD;
      HOLD:   if (bus.ready) state_n = SETTLE;
      default:               state_n = SETTLE;
    endcase
  end

  always_comb begin
    capture   = (state == SETTLE) & is_new;
    set_ovr   = (state == HOLD) & is_new & ~bus.ready;
    bus.valid = (state == HOLD);
  end

  // A pattern dropped in HOLD leaves last_rep untouched so it is re-offered later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= 8'h00;
      err_q    <= 2'b00;
      last_rep <= '0;
      first    <= 1'b1;
      ovr      <= 1'b0;
    end else begin
      if (capture) begin
        data_q   <= {nib_a, nib_b};
        err_q    <= {err_a, err_b};
        last_rep <= sample;
        first    <= 1'b0;
      end
      if (set_ovr)      ovr <= 1'b1;
      else if (clr_ovr) ovr <= 1'b0;
    end
  end

  assign bus.data = data_q;
  assign bus.err  = err_q;

endmodule
